// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the program-ROM port arbiter.
// PMEM_ARB_STARVE_EN (optional) enables the IF anti-starvation counter.
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } pmem_owner_e;

  localparam int unsigned PMEM_WORD_W = 32;
  localparam int unsigned PMEM_DEPTH  = 256;

endpackage

// File: rtl/pmem_arb_grant.sv
// Grant logic for the program-ROM port: D-side priority, with an optional IF starvation breaker.
// Define PMEM_ARB_STARVE_EN to build the denial counter; otherwise priority is strict.
module pmem_arb_grant
  import pmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

`ifdef PMEM_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            force_if;

  assign force_if = if_req && (starve_cnt_q == CntW'(STARVE_MAX));

  always_comb begin
    if_gnt       = if_req && (!d_req || force_if);
    d_gnt        = d_req && !force_if;
    starve_cnt_d = '0;
    // Count consecutive denied IF cycles; any IF grant or dropped request clears it.
    if (if_req && !if_gnt && (starve_cnt_q != CntW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_cfg;

  // Strict priority is purely combinational; clock, reset and threshold go unused.
  assign unused_cfg = clk ^ rst_n ^ (STARVE_MAX != 0);

  always_comb begin
    if_gnt = if_req && !d_req;
    d_gnt  = d_req;
  end
`endif

endmodule

// File: rtl/pmem_port_arb.sv
// Shares the single 1-cycle read port of the program ROM between instruction fetch and D-side loads.
// Build option PMEM_ARB_STARVE_EN adds a forced IF grant after STARVE_MAX consecutive denials.
module pmem_port_arb
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req_c0,
  input  logic [ADDR_W-1:0]      if_addr_c0,
  output logic                   if_gnt_c0,
  output logic                   if_rvalid_c1,
  output logic [PMEM_WORD_W-1:0] if_rdata_c1,
  input  logic                   d_req_c0,
  input  logic [ADDR_W-1:0]      d_addr_c0,
  output logic                   d_gnt_c0,
  output logic                   d_rvalid_c1,
  output logic [PMEM_WORD_W-1:0] d_rdata_c1,
  output logic [ADDR_W-1:0]      pmem_addr_c0,
  input  logic [PMEM_WORD_W-1:0] pmem_rdata_c1
);

  pmem_owner_e       owner_q, owner_d;
  logic [ADDR_W-1:0] last_addr_q;

  pmem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (if_req_c0),
    .d_req  (d_req_c0),
    .if_gnt (if_gnt_c0),
    .d_gnt  (d_gnt_c0)
  );

  // With no grant the ROM keeps seeing the previous address, so its output stays put.
  always_comb begin
    owner_d      = OWN_NONE;
    pmem_addr_c0 = last_addr_q;
    if (if_gnt_c0) begin
      owner_d      = OWN_IF;
      pmem_addr_c0 = if_addr_c0;
    end else if (d_gnt_c0) begin
      owner_d      = OWN_D;
      pmem_addr_c0 = d_addr_c0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      last_addr_q <= '0;
    end else begin
      owner_q     <= owner_d;
      last_addr_q <= pmem_addr_c0;
    end
  end

  assign if_rvalid_c1 = (owner_q == OWN_IF);
  assign d_rvalid_c1  = (owner_q == OWN_D);
  assign if_rdata_c1  = if_rvalid_c1 ? pmem_rdata_c1 : '0;
  assign d_rdata_c1   = d_rvalid_c1 ? pmem_rdata_c1 : '0;

endmodule

// File: tb/tb_pmem_port_arb.sv
// Scoreboard bench for pmem_port_arb: directed scenarios plus a random request stream against a
// behavioural ROM and arbitration model.
module tb_pmem_port_arb;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk, rst_n;
  logic              if_req, d_req;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic              if_gnt, d_gnt, if_rvalid, d_rvalid;
  logic [31:0]       if_rdata, d_rdata, pmem_rdata;
  logic [ADDR_W-1:0] pmem_addr;

  pmem_port_arb #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_c0     (if_req),
    .if_addr_c0    (if_addr),
    .if_gnt_c0     (if_gnt),
    .if_rvalid_c1  (if_rvalid),
    .if_rdata_c1   (if_rdata),
    .d_req_c0      (d_req),
    .d_addr_c0     (d_addr),
    .d_gnt_c0      (d_gnt),
    .d_rvalid_c1   (d_rvalid),
    .d_rdata_c1    (d_rdata),
    .pmem_addr_c0  (pmem_addr),
    .pmem_rdata_c1 (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PMEM_0: synchronous read, word index addr[9:2].
  logic [31:0] rom [256];
  always @(posedge clk) pmem_rdata <= rom[pmem_addr[9:2]];

  int unsigned cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_tests, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: consecutive IF denials and the last address presented to the ROM.
  int                denial_run;
  logic [ADDR_W-1:0] model_last;
  logic              exp_if, exp_d;
  int                if_gnt_seen;

  task automatic model_reset();
    denial_run = 0;
    model_last = '0;
  endtask

  task automatic step(input logic ir, input logic [ADDR_W-1:0] ia,
                      input logic dr, input logic [ADDR_W-1:0] da);
    logic force_if;
    logic [ADDR_W-1:0] ea;
    exp_t e;
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    #1;
    force_if = 1'b0;
`ifdef PMEM_ARB_STARVE_EN
    force_if = ir && (denial_run >= STARVE_MAX);
`endif
    exp_if = ir && (!dr || force_if);
    exp_d  = dr && !force_if;
    ea = exp_if ? ia : (exp_d ? da : model_last);
    check("if_gnt", 32'(if_gnt), 32'(exp_if));
    check("d_gnt", 32'(d_gnt), 32'(exp_d));
    check("double_gnt", 32'(if_gnt & d_gnt), 32'd0);
    check("pmem_addr", 32'(pmem_addr), 32'(ea));
    if (if_gnt) if_gnt_seen++;
    denial_run = (ir && !exp_if) ? denial_run + 1 : 0;
    model_last = ea;
    if (exp_if || exp_d) begin
      e.due  = cyc + 1;
      e.is_d = exp_d;
      e.data = rom[ea[9:2]];
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every response must match the oldest outstanding grant, arriving exactly one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!if_rvalid) check("if_rdata_idle", if_rdata, 32'd0);
      if (!d_rvalid) check("d_rdata_idle", d_rdata, 32'd0);
      if (if_rvalid && d_rvalid) check("both_rvalid", 32'd1, 32'd0);
      else if (if_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_latency", cyc, e.due);
          check("rvalid_owner", 32'(d_rvalid), 32'(e.is_d));
          check("rdata", d_rvalid ? d_rdata : if_rdata, e.data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_rvalid", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    logic              ip, dp;
    logic [ADDR_W-1:0] ia, da;
    n_tests = 0; n_fail = 0; if_gnt_seen = 0;
    foreach (rom[i]) rom[i] = $urandom;
    rom[0]  = 32'h00000113;
    rom[1]  = 32'h00000413;
    rom[2]  = 32'h00000013;
    rom[29] = 32'hff010113;
    rom[30] = 32'h012347b7;
    model_reset();
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0;
    #3;
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_pmem_addr", 32'(pmem_addr), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // IF-only back-to-back fetch.
    step(1, 10'h000, 0, 0);
    step(1, 10'h004, 0, 0);
    step(1, 10'h008, 0, 0);
    step(0, 0, 0, 0);
    // Conflict: D wins, IF follows once D drops.
    step(1, 10'h074, 1, 10'h078);
    step(1, 10'h074, 0, 0);
    step(0, 0, 0, 0);
    // Single D read then idle: address must hold.
    step(0, 0, 1, 10'h00C);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("idle_hold_addr", 32'(pmem_addr), 32'h00C);

    // Reset before the granted read is captured: it must never produce rvalid.
    step(1, 10'h010, 0, 0);
    #2 rst_n = 1'b0;
    if_req = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_mid_pmem_addr", 32'(pmem_addr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0);
      check("rst_mid_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_mid_if_rdata", if_rdata, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Both requesters held high continuously.
    if_gnt_seen = 0;
    for (int i = 0; i < 20; i++) step(1, 10'h040, 1, 10'h080);
`ifdef PMEM_ARB_STARVE_EN
    check("starve_if_grants", 32'(if_gnt_seen), 32'd4);
`else
    check("starve_if_grants", 32'(if_gnt_seen), 32'd0);
`endif
    step(0, 0, 0, 0);
    model_reset_counter_only: denial_run = 0;

    // Random streams; a pending request keeps its address until granted.
    ip = 1'b0; dp = 1'b0; ia = '0; da = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!ip) begin ip = ($urandom_range(0, 1) == 1); ia = ADDR_W'($urandom); end
      if (!dp) begin dp = ($urandom_range(0, 2) == 0); da = ADDR_W'($urandom); end
      step(ip, ia, dp, da);
      if (exp_if) ip = 1'b0;
      if (exp_d) dp = 1'b0;
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
